// File: rtl/bar_word_pkg.sv
// rtl/bar_word_pkg.sv - shared bar word / foo beat types for the bar-to-foo serializer
package bar_word_pkg;

  // One word as it arrives on the bar interface.
  typedef struct packed {
    logic [31:0] bar;
  } bar_word_t;

  // One beat as it leaves on the foo interface.
  typedef logic [7:0] foo_beat_t;

  // Number of foo beats needed to carry one bar word.
  localparam int BAR_NBEATS = $bits(bar_word_t) / $bits(foo_beat_t);

endpackage : bar_word_pkg

// File: rtl/bar_word_serializer.sv
// rtl/bar_word_serializer.sv - splits IN_W bar words into OUT_W foo beats; BAR_SERIALIZER_CAST_MODE_EN sends one cast beat per word
module bar_word_serializer
  import bar_word_pkg::*;
#(
  parameter int IN_W      = $bits(bar_word_t),
  parameter int OUT_W     = $bits(foo_beat_t),
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_bar,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_foo,
  output logic             out_last,
  output logic             busy
);

  localparam int NBEATS = IN_W / OUT_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  // A word must split into a whole number of beats.
  if ((OUT_W < 1) || ((IN_W % OUT_W) != 0)) begin : g_width_check
    $error("bar_word_serializer: IN_W (%0d) must be a multiple of OUT_W (%0d)", IN_W, OUT_W);
  end

  logic [0:0] state;
  logic       take_word;
  logic       beat_xfer;

  // SHIFT means a word is held and its current beat is on out_foo.
  assign out_valid = (state == S_SHIFT);
  assign busy      = (state == S_SHIFT);
  assign beat_xfer = out_valid && out_ready;

  // Accept while idle, or in the cycle the last beat leaves so the next word follows with no bubble.
  assign in_ready  = (state == S_IDLE) || (out_last && out_ready);
  assign take_word = in_valid && in_ready;

  // Control FSM: stay in SHIFT while words keep arriving back to back, drop to IDLE after a lone last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (take_word) begin
      state <= S_SHIFT;
    end else if (beat_xfer && out_last) begin
      state <= S_IDLE;
    end
  end

`ifdef BAR_SERIALIZER_CAST_MODE_EN

  logic [OUT_W-1:0] hold;

  // Only the low OUT_W bits of a word survive the cast, so only those are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (take_word) begin
      hold <= in_bar[OUT_W-1:0];
    end
  end

  assign out_foo  = hold;
  assign out_last = out_valid;

`else

  logic [IN_W-1:0]  hold;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] slices [NBEATS];

  // Holding register: captures the whole word on acceptance and keeps it until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (take_word) begin
      hold <= in_bar;
    end
  end

  // Beat counter: restarts at 0 for each new word and only advances on a real transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (take_word) begin
      cnt <= '0;
    end else if (beat_xfer && !out_last) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Slice table ordered by transmit position, so the counter indexes it directly for either bit order.
  for (genvar i = 0; i < NBEATS; i++) begin : g_slice
    localparam int SRC = (LSB_FIRST != 0) ? i : (NBEATS - 1 - i);
    assign slices[i] = hold[SRC*OUT_W +: OUT_W];
  end

  if (NBEATS == 1) begin : g_single
    assign out_foo  = slices[0];
    assign out_last = out_valid;
  end else begin : g_multi
    assign out_foo  = slices[cnt];
    assign out_last = out_valid && (cnt == CNT_W'(NBEATS - 1));
  end

`endif

endmodule : bar_word_serializer

// File: tb/tb_bar_word_serializer.sv
// tb/tb_bar_word_serializer.sv - scoreboard bench for bar_word_serializer, LSB-first and MSB-first instances side by side
interface bar_if #(parameter int W = 32);
  logic         valid;
  logic         ready;
  logic [W-1:0] bar;
endinterface

interface foo_if #(parameter int W = 8);
  logic         valid;
  logic         ready;
  logic [W-1:0] foo;
  logic         last;
endinterface

module tb_bar_word_serializer;
  import bar_word_pkg::*;

  localparam int IN_W  = 32;
  localparam int OUT_W = 8;
  localparam int NB    = IN_W / OUT_W;
`ifdef BAR_SERIALIZER_CAST_MODE_EN
  localparam int EB = 1;
`else
  localparam int EB = NB;
`endif

  typedef struct {
    logic [7:0] foo;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic out_ready = 1'b1;
  logic rand_rdy = 1'b0;
  logic in_ready_m;
  logic busy_l, busy_m;

  int n_cmp = 0;
  int n_bad = 0;

  beat_t sb [2][$];
  logic       stall [2];
  logic [7:0] prev_foo [2];
  logic       prev_last [2];

  logic       mon_v [2];
  logic [7:0] mon_foo [2];
  logic       mon_last [2];
  logic       mon_busy [2];

  always #5 clk = ~clk;

  bar_if #(.W(IN_W))  bar ();
  foo_if #(.W(OUT_W)) foo_l ();
  foo_if #(.W(OUT_W)) foo_m ();

  assign foo_l.ready = out_ready;
  assign foo_m.ready = out_ready;

  bar_word_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(bar.valid), .in_ready(bar.ready), .in_bar(bar.bar),
    .out_valid(foo_l.valid), .out_ready(foo_l.ready), .out_foo(foo_l.foo),
    .out_last(foo_l.last), .busy(busy_l)
  );

  bar_word_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(bar.valid), .in_ready(in_ready_m), .in_bar(bar.bar),
    .out_valid(foo_m.valid), .out_ready(foo_m.ready), .out_foo(foo_m.foo),
    .out_last(foo_m.last), .busy(busy_m)
  );

  assign mon_v[0] = foo_l.valid;     assign mon_v[1] = foo_m.valid;
  assign mon_foo[0] = foo_l.foo;     assign mon_foo[1] = foo_m.foo;
  assign mon_last[0] = foo_l.last;   assign mon_last[1] = foo_m.last;
  assign mon_busy[0] = busy_l;       assign mon_busy[1] = busy_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: beat k of a word is plain arithmetic on the word value.
  task automatic push_word(input logic [31:0] w);
    beat_t b;
    for (int k = 0; k < EB; k++) begin
`ifdef BAR_SERIALIZER_CAST_MODE_EN
      b.foo = 8'(w % 256);
      b.last = 1'b1;
      sb[0].push_back(b);
      sb[1].push_back(b);
`else
      b.last = (k == NB - 1);
      b.foo = 8'((w / (32'd1 << (8 * k))) % 256);
      sb[0].push_back(b);
      b.foo = 8'((w / (32'd1 << (8 * (NB - 1 - k)))) % 256);
      sb[1].push_back(b);
`endif
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send_word(input logic [31:0] w);
    bit done = 0;
    bar.valid = 1'b1;
    bar.bar = w;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (bar.ready) begin
        push_word(w);
        done = 1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: word %h never accepted", w);
    end
    @(posedge clk);
    #1;
    bar.valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      if (sb[0].size() == 0 && sb[1].size() == 0 && !foo_l.valid && !foo_m.valid) done = 1;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d/%0d beats outstanding, required 0", sb[0].size(), sb[1].size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid_l"}, foo_l.valid, 0);
    check({tag, "_valid_m"}, foo_m.valid, 0);
    check({tag, "_ready_l"}, bar.ready, 1);
    check({tag, "_ready_m"}, in_ready_m, 1);
    check({tag, "_busy"}, busy_l | busy_m, 0);
    check({tag, "_foo"}, {foo_l.foo, foo_m.foo}, 0);
    check({tag, "_last"}, foo_l.last | foo_m.last, 0);
  endtask

  // Monitor: pops the scoreboard on every transfer and guards stalled beats.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall[0] = 0;
      stall[1] = 0;
    end else begin
      check("in_ready_match", in_ready_m, bar.ready);
      for (int i = 0; i < 2; i++) begin
        check(i ? "busy_m" : "busy_l", mon_busy[i], mon_v[i]);
        if (stall[i]) begin
          check(i ? "stall_valid_m" : "stall_valid_l", mon_v[i], 1);
          check(i ? "stall_foo_m" : "stall_foo_l", mon_foo[i], prev_foo[i]);
          check(i ? "stall_last_m" : "stall_last_l", mon_last[i], prev_last[i]);
        end
        if (mon_v[i] && out_ready) begin
          if (sb[i].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_beat_%0d: got %h, required no beat", i, mon_foo[i]);
          end else begin
            beat_t e;
            e = sb[i].pop_front();
            check(i ? "beat_foo_m" : "beat_foo_l", mon_foo[i], e.foo);
            check(i ? "beat_last_m" : "beat_last_l", mon_last[i], e.last);
          end
        end
        stall[i] = mon_v[i] && !out_ready;
        prev_foo[i] = mon_foo[i];
        prev_last[i] = mon_last[i];
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bar.valid = 1'b0;
    bar.bar = '0;
    #2;
    check_reset_state("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word, LSB first: first beat the cycle after acceptance, in_ready only on the last beat.
    send_word(32'h04030205);
    for (int k = 0; k < EB; k++) begin
      @(negedge clk);
      check("single_valid", foo_l.valid, 1);
      check("single_in_ready", bar.ready, (k == EB - 1));
      if (k == 0) check("single_first_beat", foo_l.foo, 8'h05);
    end
    @(negedge clk);
    check("single_valid_drop", foo_l.valid, 0);
    @(posedge clk);
    #1;

    // Backpressure: stall the second beat (the only beat in cast mode) for three cycles.
    send_word(32'h04030205);
`ifndef BAR_SERIALIZER_CAST_MODE_EN
    @(posedge clk);
    #1;
`endif
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_foo", foo_l.foo, (EB == 1) ? 8'h05 : 8'h02);
      check("bp_in_ready", bar.ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain();

    // Back to back: no idle cycle across the word boundary.
    fork
      begin
        send_word(32'hA3A2A1A0);
        send_word(32'hB3B2B1B0);
      end
      begin
        bit seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
          @(negedge clk);
          if (foo_l.valid) seen = 1;
        end
        check("b2b_started", seen, 1);
        for (int k = 0; k < 2 * EB; k++) begin
          if (k > 0) @(negedge clk);
          check("b2b_valid", foo_l.valid, 1);
          check("b2b_in_ready", bar.ready, ((k % EB) == EB - 1));
        end
      end
    join
    wait_drain();

    // MSB-first on the second instance.
    send_word(32'h11223344);
    @(negedge clk);
    check("msb_first_beat", foo_m.foo, (EB == 1) ? 8'h44 : 8'h11);
    wait_drain();

    // Reset in the middle of a word, asynchronously between clock edges.
    send_word(32'hDEADBEEF);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    sb[0].delete();
    sb[1].delete();
    #1;
    check_reset_state("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_word(32'h00000005);
    @(negedge clk);
    check("post_reset_beat0", foo_l.foo, 8'h05);
    wait_drain();

    // Randomized words, gaps and downstream stalls.
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_word($urandom);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_bar_word_serializer
